// File: rtl/ste_bus_arbiter.sv
// STE system-bus arbiter: sequences BR/BG/BGACK between the CPU, DMA and blitter.
// Define STE_BLITTER_EN to arbitrate the blitter port; otherwise only DMA is granted.
module ste_bus_arbiter #(
    parameter int unsigned GRANT_TIMEOUT = 16
) (
    input  logic       clk32,
    input  logic       resb,
    input  logic       mhz8_en1,
    input  logic       as_n,
    input  logic       dma_br_n,
    input  logic       dma_bgack_n,
    output logic       dma_bg_n,
    input  logic       blt_br_n,
    input  logic       blt_bgack_n,
    output logic       blt_bg_n,
    output logic       bgack_n,
    output logic       bus_free,
    output logic [1:0] owner,
    output logic       timeout
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_OWN   = 2'd2,
        ST_TURN  = 2'd3
    } state_e;

    localparam logic [7:0] TMO_LIMIT = 8'(GRANT_TIMEOUT);

    state_e     state_q, state_d;
    logic       sel_q, sel_d;
    logic [7:0] cnt_q, cnt_d;
    logic       revoke;

    logic       dma_bg_q, dma_bg_d;
    logic       blt_bg_q, blt_bg_d;
    logic [1:0] owner_q, owner_d;
    logic       timeout_q, timeout_d;

    logic       blt_br_eff;
    logic       blt_bgack_eff;
    logic       sel_br_n;
    logic       sel_bgack_n;
    logic [7:0] cnt_inc;

`ifdef STE_BLITTER_EN
    assign blt_br_eff    = blt_br_n;
    assign blt_bgack_eff = blt_bgack_n;
`else
    // Blitter inputs are deliberately ignored in the DMA-only build.
    logic unused_blt;
    assign unused_blt    = blt_br_n & blt_bgack_n;
    assign blt_br_eff    = 1'b1;
    assign blt_bgack_eff = 1'b1;
`endif

    assign sel_br_n    = sel_q ? blt_br_eff    : dma_br_n;
    assign sel_bgack_n = sel_q ? blt_bgack_eff : dma_bgack_n;
    assign cnt_inc     = cnt_q + 8'd1;

    always_ff @(posedge clk32) begin
        if (!resb) begin
            state_q   <= ST_IDLE;
            sel_q     <= 1'b0;
            cnt_q     <= '0;
            dma_bg_q  <= 1'b1;
            blt_bg_q  <= 1'b1;
            owner_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            cnt_q     <= cnt_d;
            dma_bg_q  <= dma_bg_d;
            blt_bg_q  <= blt_bg_d;
            owner_q   <= owner_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        revoke  = 1'b0;
        if (mhz8_en1) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (as_n && dma_bgack_n && blt_bgack_eff) begin
                        if (!dma_br_n) begin
                            state_d = ST_GRANT;
                            sel_d   = 1'b0;
                            cnt_d   = '0;
                        end else if (!blt_br_eff) begin
                            state_d = ST_GRANT;
                            sel_d   = 1'b1;
                            cnt_d   = '0;
                        end
                    end
                end
                ST_GRANT: begin
                    cnt_d = cnt_inc;
                    if (!sel_bgack_n) begin
                        state_d = ST_OWN;
                    end else if (sel_br_n) begin
                        state_d = ST_IDLE;
                    end else if (cnt_inc == TMO_LIMIT) begin
                        state_d = ST_IDLE;
                        revoke  = 1'b1;
                    end
                end
                ST_OWN: begin
                    if (sel_bgack_n) begin
                        state_d = ST_TURN;
                    end
                end
                ST_TURN: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so a grant appears on the very tick edge that issues it.
    always_comb begin
        dma_bg_d  = !((state_d == ST_GRANT) && !sel_d);
        blt_bg_d  = !((state_d == ST_GRANT) && sel_d);
        owner_d   = '0;
        if (state_d == ST_OWN) begin
            owner_d = sel_d ? 2'b10 : 2'b01;
        end
        timeout_d = revoke;
    end

    assign dma_bg_n = dma_bg_q;
`ifdef STE_BLITTER_EN
    assign blt_bg_n = blt_bg_q;
`else
    logic unused_blt_bg;
    assign unused_blt_bg = blt_bg_q;
    assign blt_bg_n      = 1'b1;
`endif
    assign owner    = owner_q;
    assign timeout  = timeout_q;
    assign bgack_n  = dma_bgack_n & blt_bgack_eff;
    assign bus_free = (state_q == ST_IDLE) & dma_bgack_n & blt_bgack_eff;

endmodule

// File: tb/tb_ste_bus_arbiter.sv
// Randomised and directed bench for ste_bus_arbiter against a tick-level handshake model.
module tb_ste_bus_arbiter;

    localparam int unsigned TMO = 4;
`ifdef STE_BLITTER_EN
    localparam bit BLT_EN = 1'b1;
`else
    localparam bit BLT_EN = 1'b0;
`endif

    logic       clk32 = 1'b0;
    logic       resb, mhz8_en1, as_n;
    logic       dma_br_n, dma_bgack_n, blt_br_n, blt_bgack_n;
    logic       dma_bg_n, blt_bg_n, bgack_n, bus_free, timeout;
    logic [1:0] owner;

    always #5 clk32 = ~clk32;

    ste_bus_arbiter #(.GRANT_TIMEOUT(TMO)) dut (
        .clk32      (clk32),
        .resb       (resb),
        .mhz8_en1   (mhz8_en1),
        .as_n       (as_n),
        .dma_br_n   (dma_br_n),
        .dma_bgack_n(dma_bgack_n),
        .dma_bg_n   (dma_bg_n),
        .blt_br_n   (blt_br_n),
        .blt_bgack_n(blt_bgack_n),
        .blt_bg_n   (blt_bg_n),
        .bgack_n    (bgack_n),
        .bus_free   (bus_free),
        .owner      (owner),
        .timeout    (timeout)
    );

    // Model: who holds an outstanding grant, who owns the bus, whether the CPU cool-off tick is due.
    int          m_grantee;
    int          m_age;
    int          m_owner;
    bit          m_cool;
    bit          m_tmo;
    int          n_checks = 0;
    int          n_errors = 0;
    int unsigned cyc = 0;
    int          tmo_seen = 0;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit eff_blt_br();
        return BLT_EN ? blt_br_n : 1'b1;
    endfunction

    function automatic bit eff_blt_bgack();
        return BLT_EN ? blt_bgack_n : 1'b1;
    endfunction

    function automatic bit bgack_of(input int m);
        return (m == 1) ? dma_bgack_n : eff_blt_bgack();
    endfunction

    function automatic bit br_of(input int m);
        return (m == 1) ? dma_br_n : eff_blt_br();
    endfunction

    task automatic model_update();
        m_tmo = 1'b0;
        if (!resb) begin
            m_grantee = 0;
            m_age     = 0;
            m_owner   = 0;
            m_cool    = 1'b0;
        end else if (mhz8_en1) begin
            if (m_cool) begin
                m_cool = 1'b0;
            end else if (m_owner != 0) begin
                if (bgack_of(m_owner)) begin
                    m_owner = 0;
                    m_cool  = 1'b1;
                end
            end else if (m_grantee != 0) begin
                if (!bgack_of(m_grantee)) begin
                    m_owner   = m_grantee;
                    m_grantee = 0;
                end else if (br_of(m_grantee)) begin
                    m_grantee = 0;
                end else begin
                    m_age++;
                    if (m_age == TMO) begin
                        m_grantee = 0;
                        m_tmo     = 1'b1;
                    end
                end
            end else if (as_n && dma_bgack_n && eff_blt_bgack()) begin
                if (!dma_br_n) begin
                    m_grantee = 1;
                    m_age     = 0;
                end else if (!eff_blt_br()) begin
                    m_grantee = 2;
                    m_age     = 0;
                end
            end
        end
    endtask

    task automatic compare();
        bit idle;
        idle = (m_grantee == 0) && (m_owner == 0) && !m_cool;
        check_eq("dma_bg_n", int'(dma_bg_n), (m_grantee == 1) ? 0 : 1);
        check_eq("blt_bg_n", int'(blt_bg_n), (m_grantee == 2) ? 0 : 1);
        check_eq("owner",    int'(owner),    m_owner);
        check_eq("timeout",  int'(timeout),  int'(m_tmo));
        check_eq("bgack_n",  int'(bgack_n),  int'(dma_bgack_n & eff_blt_bgack()));
        check_eq("bus_free", int'(bus_free), int'(idle & dma_bgack_n & eff_blt_bgack()));
        if (timeout === 1'b1) tmo_seen++;
    endtask

    task automatic step();
        @(posedge clk32);
        model_update();
        #1;
        compare();
        cyc++;
        mhz8_en1 = (cyc % 4 == 3);
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    initial begin
        resb        = 1'b0;
        mhz8_en1    = 1'b0;
        as_n        = 1'b1;
        dma_br_n    = 1'b1;
        dma_bgack_n = 1'b1;
        blt_br_n    = 1'b1;
        blt_bgack_n = 1'b1;
        m_grantee = 0; m_age = 0; m_owner = 0; m_cool = 1'b0; m_tmo = 1'b0;
        run(6);
        resb = 1'b1;
        run(4);

        // Basic DMA cycle
        dma_br_n = 1'b0;         run(8);
        dma_bgack_n = 1'b0;      run(8);
        dma_br_n = 1'b1;         run(4);
        dma_bgack_n = 1'b1;      run(12);

        // Simultaneous requests: DMA first, blitter after the turnaround
        dma_br_n = 1'b0; blt_br_n = 1'b0; run(8);
        dma_bgack_n = 1'b0; dma_br_n = 1'b1; run(8);
        dma_bgack_n = 1'b1;      run(12);
        blt_bgack_n = 1'b0;      run(8);
        blt_br_n = 1'b1; blt_bgack_n = 1'b1; run(12);

        // CPU busy then released, followed by an abort
        as_n = 1'b0; dma_br_n = 1'b0; run(20);
        as_n = 1'b1;             run(6);
        dma_br_n = 1'b1;         run(8);
        check_eq("abort_no_timeout", tmo_seen, 0);

        // Timeout with a request that never gets acknowledged, then re-grant
        dma_br_n = 1'b0;         run(44);
        check_eq("timeout_pulses", tmo_seen >= 2 ? 1 : 0, 1);
        dma_br_n = 1'b1;         run(8);

        // Reset asserted off-tick while the DMA owns the bus
        dma_br_n = 1'b0;         run(8);
        dma_bgack_n = 1'b0;      run(8);
        while (cyc % 4 != 0) step();
        resb = 1'b0;             step();
        resb = 1'b1;             run(6);
        dma_br_n = 1'b1; dma_bgack_n = 1'b1; run(12);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(5) == 0) as_n        = ~as_n;
            if ($urandom_range(5) == 0) dma_br_n    = ~dma_br_n;
            if ($urandom_range(7) == 0) dma_bgack_n = ~dma_bgack_n;
            if ($urandom_range(5) == 0) blt_br_n    = ~blt_br_n;
            if ($urandom_range(7) == 0) blt_bgack_n = ~blt_bgack_n;
            resb = ($urandom_range(299) != 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
